k005297_maskreg: RTL

- Consumer side of the mask-load strobe `i_MSKREG_SR_LD`, which the mask load timer produces.
- The CPU/bus side writes a mask word into a holding register.
- On each load strobe the held word is transferred into a shift register.
- The shift register is then shifted out one bit per bubble-rotation slot. The serial result, `o_MSK_BIT`, is the per-position mask applied to the bubble data path.

---
 rtl/k005297_maskreg_pkg.sv | 19 +
 rtl/k005297_maskreg_hold.sv | 48 ++++
 rtl/k005297_maskreg.sv | 126 ++++++++++++
 3 files changed

// File: rtl/k005297_maskreg_pkg.sv
// ---------------------------------------------------------------------------
// k005297_maskreg_pkg
// Shared constants for the bubble-memory mask register slice:
//   MASK_W_DEFAULT : default width of the mask word / shift register
//   SLOT_*         : rotation slot indices that carry a mask shift
//   ROT_W          : width of the one-cold rotation slot bus
// ---------------------------------------------------------------------------
package k005297_maskreg_pkg;

   localparam int MASK_W_DEFAULT = 16;
   localparam int ROT_W          = 20;

   // Slots 0 and 5 shift in both modes; 10 and 15 only in 4-bit mode.
   localparam int SLOT_0  = 0;
   localparam int SLOT_5  = 5;
   localparam int SLOT_10 = 10;
   localparam int SLOT_15 = 15;

endpackage : k005297_maskreg_pkg

// File: rtl/k005297_maskreg_hold.sv
// ---------------------------------------------------------------------------
// k005297_maskreg_hold
// Holding register written from the bus side and consumed by the shift
// register load.
//   clk     : master clock
//   rst     : asynchronous active-high reset
//   wr_en   : qualified bus write (already gated by the 4 MHz enable)
//   din     : bus write data
//   consume : qualified load that takes the held word
//   hold_q  : held mask word
//   full    : held word has not been consumed yet
// ---------------------------------------------------------------------------
module k005297_maskreg_hold
   import k005297_maskreg_pkg::*;
#(
   parameter int MASK_W = MASK_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [MASK_W-1:0] din,
   input  logic              consume,
   output logic [MASK_W-1:0] hold_q,
   output logic              full
);

   // NOTE: state is updated with non-blocking assignments so that a consumer
   // reading hold_q on the same edge as a write still sees the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data word is reset too; it is a single register, not a
         // memory array, and a defined value keeps an underrun load harmless.
         hold_q <= '0;
         full   <= 1'b0;
      end else begin
         if (wr_en) begin
            hold_q <= din;
         end
         // A write on the consume edge refills the register, so full stays set.
         if (wr_en) begin
            full <= 1'b1;
         end else if (consume) begin
            full <= 1'b0;
         end
      end
   end

endmodule : k005297_maskreg_hold

// File: rtl/k005297_maskreg.sv
// ---------------------------------------------------------------------------
// k005297_maskreg
// Mask register: the bus writes a mask word into a holding register, each
// load strobe moves it into a shift register, and one mask bit is shifted
// out per active bubble-rotation slot.
//   i_MCLK         : master clock
//   i_RST          : asynchronous active-high reset
//   i_CLK4M_PCEN_n : 4 MHz enable (active low), qualifies bus writes
//   i_CLK2M_PCEN_n : 2 MHz enable (active low), qualifies load/shift/flush
//   i_ROT20_n      : one-cold rotation slot timing
//   i_4BEN_n       : 4-bit mode enable (active low)
//   i_ACC_ACT_n    : access active (active low); high flushes the shifter
//   i_MSKREG_SR_LD : load strobe from the mask load timer
//   i_MSK_WR       : bus write strobe
//   i_DIN          : bus write data
//   o_MSK_BIT      : current mask bit (shift register MSB)
//   o_HOLD_FULL    : holding register has an unconsumed word
//   o_SR_EMPTY     : no bits remain in the shift register
//   o_UNDERRUN     : sticky, a load found the holding register empty
//   o_BITCNT       : bits remaining in the shift register
// ---------------------------------------------------------------------------
module k005297_maskreg
   import k005297_maskreg_pkg::*;
#(
   parameter int MASK_W = MASK_W_DEFAULT,
   parameter int CNT_W  = $clog2(MASK_W + 1)
) (
   input  logic              i_MCLK,
   input  logic              i_RST,
   input  logic              i_CLK4M_PCEN_n,
   input  logic              i_CLK2M_PCEN_n,
   input  logic [ROT_W-1:0]  i_ROT20_n,
   input  logic              i_4BEN_n,
   input  logic              i_ACC_ACT_n,
   input  logic              i_MSKREG_SR_LD,
   input  logic              i_MSK_WR,
   input  logic [MASK_W-1:0] i_DIN,
   output logic              o_MSK_BIT,
   output logic              o_HOLD_FULL,
   output logic              o_SR_EMPTY,
   output logic              o_UNDERRUN,
   output logic [CNT_W-1:0]  o_BITCNT
);

   logic [MASK_W-1:0] hold_q;
   logic              full;
   logic [MASK_W-1:0] sr;
   logic [CNT_W-1:0]  cnt;
   logic              underrun;

   logic tick;
   logic shift_en;
   logic flush;
   logic load;
   logic shift;
   logic unused_rot;

   // Only four slot lines matter; the rest are folded here to keep the
   // whole bus formally consumed.
   assign unused_rot = ^i_ROT20_n;

   assign tick     = ~i_CLK2M_PCEN_n;
   assign shift_en = ~i_ROT20_n[SLOT_0] | ~i_ROT20_n[SLOT_5]
                   | (~i_4BEN_n & (~i_ROT20_n[SLOT_10] | ~i_ROT20_n[SLOT_15]));

   // Priority per control tick: flush > load > shift.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      flush = 1'b0;
      load  = 1'b0;
      shift = 1'b0;
      if (tick) begin
         if (i_ACC_ACT_n) begin
            flush = 1'b1;
         end else if (i_MSKREG_SR_LD) begin
            load = 1'b1;
         end else if (shift_en && (cnt != '0)) begin
            shift = 1'b1;
         end
      end
   end

   k005297_maskreg_hold #(
      .MASK_W (MASK_W)
   ) u_hold (
      .clk     (i_MCLK),
      .rst     (i_RST),
      .wr_en   (~i_CLK4M_PCEN_n & i_MSK_WR),
      .din     (i_DIN),
      .consume (load & full),
      .hold_q  (hold_q),
      .full    (full)
   );

   always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
         sr       <= '0;
         cnt      <= '0;
         underrun <= 1'b0;
      end else begin
         if (flush) begin
            sr  <= '0;
            cnt <= '0;
         end else if (load) begin
            // An empty holding register loads zeros but still restarts the
            // count, so the rotation timing stays aligned.
            sr  <= full ? hold_q : '0;
            cnt <= CNT_W'(MASK_W);
            if (!full) begin
               underrun <= 1'b1;
            end
         end else if (shift) begin
            sr  <= {sr[MASK_W-2:0], 1'b0};
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   assign o_MSK_BIT   = sr[MASK_W-1];
   assign o_HOLD_FULL = full;
   assign o_SR_EMPTY  = (cnt == '0);
   assign o_UNDERRUN  = underrun;
   assign o_BITCNT    = cnt;

endmodule : k005297_maskreg
